// File: rtl/uart_tx_frame.sv
// uart_tx_frame: valid/ready UART transmitter, 5-9 data bits LSB-first, optional odd/even parity, 1-2 stop bits.
// Define UART_TX_BREAK_EN to add the brk line-break input and its BREAK/BRK_HOLD states.
module uart_tx_frame #(
    parameter int BAUD      = 104,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 start,
    output logic                 ready,
`ifdef UART_TX_BREAK_EN
    input  logic                 brk,
`endif
    output logic                 tx
);
    localparam int BW = $clog2(BAUD);
    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
`ifdef UART_TX_BREAK_EN
        , S_BREAK, S_BRK_HOLD
`endif
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [BW-1:0]        r_baud;
    logic [CW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;
    logic                 w_bit;
    logic                 w_tick;
    logic                 w_last_stop;
    logic                 w_idle_rdy;
    logic                 w_accept;

    assign w_tick      = r_baud == BAUD_LAST;
    assign w_last_stop = r_state == S_STOP && w_tick && r_bit == STOP_LAST;
`ifdef UART_TX_BREAK_EN
    assign w_idle_rdy  = r_state == S_IDLE && !brk;
`else
    assign w_idle_rdy  = r_state == S_IDLE;
`endif
    assign ready       = w_idle_rdy || w_last_stop;
    assign w_accept    = start && ready;
    assign tx          = r_tx;

    // state register; reset discards any frame in flight
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) r_state <= S_IDLE;
        else r_state <= w_next;

    // next state and the line level the current state wants on tx
    always_comb begin
        w_next = r_state;
        w_bit  = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_START;
`ifdef UART_TX_BREAK_EN
                else if (brk) w_next = S_BREAK;
`endif
            end
            S_START: begin
                w_bit = 1'b0;
                if (w_tick) w_next = S_DATA;
            end
            S_DATA: begin
                w_bit = r_shift[0];
                if (w_tick && r_bit == DATA_LAST) w_next = PARITY != 0 ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                w_bit = r_par;
                if (w_tick) w_next = S_STOP;
            end
            S_STOP: begin
                if (w_last_stop) w_next = w_accept ? S_START : S_IDLE;
            end
`ifdef UART_TX_BREAK_EN
            S_BREAK: begin
                w_bit = 1'b0;
                if (!brk) w_next = S_BRK_HOLD;
            end
            S_BRK_HOLD: begin
                if (w_tick) w_next = S_IDLE;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // baud/bit counters, shift register, latched parity and registered tx (one cycle behind state)
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_baud <= (w_tick || w_next != r_state || r_state == S_IDLE) ? '0 : r_baud + 1'b1;
            r_bit  <= w_next != r_state ? '0
                    : (w_tick && (r_state == S_DATA || r_state == S_STOP)) ? r_bit + 1'b1 : r_bit;
            if (w_accept) begin
                r_shift <= data;
                r_par   <= (^data) ^ (PARITY == 1);
            end else if (r_state == S_DATA && w_tick) begin
                r_shift <= r_shift >> 1;
            end
            r_tx <= w_bit;
        end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: randomized checks of uart_tx_frame against a frame-level reference model (8N1, 8E1, 8O1, 7E2 at BAUD=4).
module tb_uart_tx_frame;
    localparam int B = 4;

    logic       clk   = 1'b0;
    logic       rstn  = 1'b1;
    logic [3:0] start = '0;
    logic [7:0] data  = '0;
    logic [3:0] ready;
    logic [3:0] tx;
`ifdef UART_TX_BREAK_EN
    logic       brk   = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit obs_tx[$];
    bit obs_rdy[$];
    bit exp_tx[$];
    bit exp_rdy[$];

    always #5 clk = ~clk;

    uart_tx_frame #(.BAUD(B), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rstn(rstn), .data(data), .start(start[0]), .ready(ready[0]),
`ifdef UART_TX_BREAK_EN
        .brk(brk),
`endif
        .tx(tx[0]));
    uart_tx_frame #(.BAUD(B), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rstn(rstn), .data(data), .start(start[1]), .ready(ready[1]),
`ifdef UART_TX_BREAK_EN
        .brk(brk),
`endif
        .tx(tx[1]));
    uart_tx_frame #(.BAUD(B), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rstn(rstn), .data(data), .start(start[2]), .ready(ready[2]),
`ifdef UART_TX_BREAK_EN
        .brk(brk),
`endif
        .tx(tx[2]));
    uart_tx_frame #(.BAUD(B), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u3 (
        .clk(clk), .rstn(rstn), .data(data[6:0]), .start(start[3]), .ready(ready[3]),
`ifdef UART_TX_BREAK_EN
        .brk(brk),
`endif
        .tx(tx[3]));

    function automatic int nb_of(input int i);
        return i == 3 ? 7 : 8;
    endfunction
    function automatic int par_of(input int i);
        return i == 1 ? 2 : i == 2 ? 1 : i == 3 ? 2 : 0;
    endfunction
    function automatic int sb_of(input int i);
        return i == 3 ? 2 : 1;
    endfunction
    function automatic int flen(input int i);
        return (1 + nb_of(i) + (par_of(i) != 0 ? 1 : 0) + sb_of(i)) * B;
    endfunction
    function automatic int first_diff(input bit a[$], input bit b[$]);
        for (int j = 0; j < a.size(); j++) if (j >= b.size() || a[j] != b[j]) return j;
        return a.size() == b.size() ? -1 : a.size();
    endfunction

    // Reference: n frames built bit by bit from the frame rules, each bit held B cycles, then idle-high.
    task automatic build_exp(input int i, input int n, input logic [7:0] w0, input logic [7:0] w1);
        int l = flen(i);
        exp_tx.delete();
        exp_rdy.delete();
        for (int m = 0; m < n; m++) begin
            logic [7:0] w = m == 0 ? w0 : w1;
            bit bits[$];
            bit x = 0;
            bits.push_back(1'b0);
            for (int j = 0; j < nb_of(i); j++) begin
                bits.push_back(w[j]);
                x ^= w[j];
            end
            if (par_of(i) != 0) bits.push_back(par_of(i) == 1 ? !x : x);
            for (int s = 0; s < sb_of(i); s++) bits.push_back(1'b1);
            foreach (bits[j]) for (int r = 0; r < B; r++) exp_tx.push_back(bits[j]);
        end
        while (exp_tx.size() < n * l + 3) exp_tx.push_back(1'b1);
        for (int c = 1; c <= n * l + 4; c++) exp_rdy.push_back(c > n * l || c % l == 0);
    endtask

    // Send n words (second one back-to-back, start held high), scramble data mid-frame, optionally poke start while busy.
    task automatic xfer(input int i, input int n, input logic [7:0] w0, input logic [7:0] w1, input bit poke);
        int l = flen(i);
        obs_tx.delete();
        obs_rdy.delete();
        @(negedge clk);
        start[i] = 1'b1;
        data     = w0;
        @(posedge clk);
        for (int c = 1; c <= n * l + 4; c++) begin
            @(negedge clk);
            obs_rdy.push_back(ready[i]);
            if (c >= 2) obs_tx.push_back(tx[i]);
            start[i] = (n == 2 && c <= l) || (poke && c == l / 2);
            data     = (n == 2 && c == l) ? w1 : 8'($urandom);
        end
        start[i] = 1'b0;
    endtask

    task automatic test_reset;
        bit bad = 0;
        #1 rstn = 1'b0;
        start = '1;
        data  = 8'hFF;
        repeat (5) begin
            @(negedge clk);
            if (tx !== 4'hF || ready !== 4'hF) bad = 1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_hold: tx=%b ready=%b, want 1111/1111", tx, ready);
        end
        start = 4'b0001;
        data  = 8'h00;
        #2 rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = '0;
        n_tests++;
        if (tx !== 4'hF || ready !== 4'b1110) begin
            n_fail++;
            $display("FAIL reset_first_accept: tx=%b ready=%b, want 1111/1110", tx, ready);
        end
        @(negedge clk);
        n_tests++;
        if (tx[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_start_bit: tx=%b want 0", tx[0]);
        end
        repeat (45) @(negedge clk);
    endtask

    task automatic test_8n1;
        logic [9:0] pat = 10'b1010101010;
        logic [9:0] got;
        int fr = -1;
        int d;
        xfer(0, 1, 8'h55, 8'h00, 1'b0);
        build_exp(0, 1, 8'h55, 8'h00);
        for (int j = 0; j < 10; j++) got[j] = obs_tx[j * B + 1];
        n_tests++;
        if (got !== pat) begin
            n_fail++;
            $display("FAIL 8n1_bits: got %b want %b", got, pat);
        end
        foreach (obs_rdy[j]) if (fr < 0 && obs_rdy[j]) fr = j + 1;
        n_tests++;
        if (fr != 40) begin
            n_fail++;
            $display("FAIL 8n1_ready_cycle: got %0d want 40", fr);
        end
        d = first_diff(obs_tx, exp_tx);
        n_tests++;
        if (d >= 0) begin
            n_fail++;
            $display("FAIL 8n1_tx: sample %0d got %b want %b", d, obs_tx[d], exp_tx[d]);
        end
    endtask

    task automatic test_parity;
        xfer(1, 1, 8'h07, 8'h00, 1'b0);
        n_tests++;
        if (obs_tx[9 * B + 1] !== 1'b1) begin
            n_fail++;
            $display("FAIL even_parity: got %b want 1", obs_tx[9 * B + 1]);
        end
        xfer(2, 1, 8'h07, 8'h00, 1'b0);
        n_tests++;
        if (obs_tx[9 * B + 1] !== 1'b0) begin
            n_fail++;
            $display("FAIL odd_parity: got %b want 0", obs_tx[9 * B + 1]);
        end
    endtask

    task automatic test_7e2;
        int fr = -1;
        logic [7:0] w = 8'($urandom);
        int d;
        xfer(3, 1, w, 8'h00, 1'b0);
        build_exp(3, 1, w, 8'h00);
        foreach (obs_rdy[j]) if (fr < 0 && obs_rdy[j]) fr = j + 1;
        n_tests++;
        if (fr != 44) begin
            n_fail++;
            $display("FAIL 7e2_frame_len: got %0d want 44", fr);
        end
        d = first_diff(obs_tx, exp_tx);
        n_tests++;
        if (d >= 0) begin
            n_fail++;
            $display("FAIL 7e2_tx: sample %0d got %b want %b", d, obs_tx[d], exp_tx[d]);
        end
    endtask

    task automatic test_back_to_back;
        int d;
        xfer(0, 2, 8'h41, 8'h42, 1'b0);
        build_exp(0, 2, 8'h41, 8'h42);
        n_tests++;
        if (obs_tx[39] !== 1'b1 || obs_tx[40] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: stop=%b start=%b want 1/0", obs_tx[39], obs_tx[40]);
        end
        d = first_diff(obs_tx, exp_tx);
        n_tests++;
        if (d >= 0) begin
            n_fail++;
            $display("FAIL b2b_tx: sample %0d got %b want %b", d, obs_tx[d], exp_tx[d]);
        end
        d = first_diff(obs_rdy, exp_rdy);
        n_tests++;
        if (d >= 0) begin
            n_fail++;
            $display("FAIL b2b_ready: cycle %0d got %b want %b", d + 1, obs_rdy[d], exp_rdy[d]);
        end
    endtask

    task automatic test_reset_midframe;
        int d;
        @(negedge clk);
        start[0] = 1'b1;
        data     = 8'h00;
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (18) @(negedge clk);
        n_tests++;
        if (tx[0] !== 1'b0 || ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_busy: tx=%b ready=%b want 0/0", tx[0], ready[0]);
        end
        #2 rstn = 1'b0;
        #1;
        n_tests++;
        if (tx[0] !== 1'b1 || ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_async: tx=%b ready=%b want 1/1", tx[0], ready[0]);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        xfer(0, 1, 8'hA3, 8'h00, 1'b0);
        build_exp(0, 1, 8'hA3, 8'h00);
        d = first_diff(obs_tx, exp_tx);
        n_tests++;
        if (d >= 0) begin
            n_fail++;
            $display("FAIL midrst_resend: sample %0d got %b want %b", d, obs_tx[d], exp_tx[d]);
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) begin
                logic [7:0] w0 = 8'($urandom);
                logic [7:0] w1 = 8'($urandom);
                int n = 1 + int'($urandom_range(0, 1));
                bit poke = 1'($urandom);
                int d;
                xfer(i, n, w0, w1, poke);
                build_exp(i, n, w0, w1);
                d = first_diff(obs_tx, exp_tx);
                n_tests++;
                if (d >= 0) begin
                    n_fail++;
                    $display("FAIL rand_tx u%0d n=%0d w=%h/%h: sample %0d got %b want %b", i, n, w0, w1, d, obs_tx[d], exp_tx[d]);
                end
                d = first_diff(obs_rdy, exp_rdy);
                n_tests++;
                if (d >= 0) begin
                    n_fail++;
                    $display("FAIL rand_ready u%0d n=%0d: cycle %0d got %b want %b", i, n, d + 1, obs_rdy[d], exp_rdy[d]);
                end
            end
        end
    endtask

`ifdef UART_TX_BREAK_EN
    task automatic test_break;
        bit et[$];
        bit er[$];
        int d;
        obs_tx.delete();
        obs_rdy.delete();
        @(negedge clk);
        brk = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            obs_tx.push_back(tx[0]);
            obs_rdy.push_back(ready[0]);
            et.push_back(!(c >= 2 && c <= 21));
            er.push_back(c >= 21 + B);
            if (c == 20) brk = 1'b0;
        end
        d = first_diff(obs_tx, et);
        n_tests++;
        if (d >= 0) begin
            n_fail++;
            $display("FAIL break_tx: cycle %0d got %b want %b", d + 1, obs_tx[d], et[d]);
        end
        d = first_diff(obs_rdy, er);
        n_tests++;
        if (d >= 0) begin
            n_fail++;
            $display("FAIL break_ready: cycle %0d got %b want %b", d + 1, obs_rdy[d], er[d]);
        end
    endtask

    task automatic test_break_midframe;
        int l = flen(0);
        logic [7:0] w = 8'($urandom);
        bit low_after = 0;
        int d;
        build_exp(0, 1, w, 8'h00);
        obs_tx.delete();
        @(negedge clk);
        start[0] = 1'b1;
        data     = w;
        @(posedge clk);
        for (int c = 1; c <= l + 14; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= l + 1) obs_tx.push_back(tx[0]);
            if (c == l + 4) low_after = tx[0] == 1'b0;
            start[0] = 1'b0;
            brk      = c >= 10 && c < l + 8;
        end
        while (exp_tx.size() > l) exp_tx.pop_back();
        d = first_diff(obs_tx, exp_tx);
        n_tests++;
        if (d >= 0) begin
            n_fail++;
            $display("FAIL brkmid_frame: sample %0d got %b want %b", d, obs_tx[d], exp_tx[d]);
        end
        n_tests++;
        if (!low_after) begin
            n_fail++;
            $display("FAIL brkmid_deferred: tx after frame got 1 want 0");
        end
        n_tests++;
        if (ready[0] !== 1'b1 || tx[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL brkmid_recover: tx=%b ready=%b want 1/1", tx[0], ready[0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_7e2();
        test_back_to_back();
        test_reset_midframe();
        test_random();
`ifdef UART_TX_BREAK_EN
        test_break();
        test_break_midframe();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
